mngr_test_agent: RTL and testbench

Test-side endpoint of the processor manager streaming ports: drives `mngr2proc` messages from a preloaded source table and accepts `proc2mngr` messages, checking each against a preloaded expected-value table. It sits in processor-with-cache benches opposite the core's mngr ports, next to the instruction/data memory models, and reports pass/fail plus the first mismatch. Synthesizable so it can also sit in FPGA self-test wrappers.

---
 rtl/mngr_test_agent_if.sv | 24 ++
 rtl/mngr_test_agent.sv | 146 ++++++++++++++
 tb/tb_mngr_test_agent.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mngr_test_agent_if.sv
// Manager streaming port bundle: mngr2proc (agent -> core) and proc2mngr (core -> agent).
// The master modport is the agent side, the slave modport is the core side.
interface mngr_test_agent_if;
   logic [31:0] mngr2proc_msg;
   logic        mngr2proc_val;
   logic        mngr2proc_rdy;
   logic [31:0] proc2mngr_msg;
   logic        proc2mngr_val;
   logic        proc2mngr_rdy;

   modport master (
      output mngr2proc_msg, mngr2proc_val,
      input  mngr2proc_rdy,
      input  proc2mngr_msg, proc2mngr_val,
      output proc2mngr_rdy
   );

   modport slave (
      input  mngr2proc_msg, mngr2proc_val,
      output mngr2proc_rdy,
      output proc2mngr_msg, proc2mngr_val,
      input  proc2mngr_rdy
   );
endinterface

// File: rtl/mngr_test_agent.sv
// Test-side manager endpoint: streams a preloaded source table and checks the core's replies
// against a preloaded sink table. Define MNGR_AGENT_RAND_DELAY_EN for LFSR-driven port stalls.
module mngr_test_agent #(
   parameter int SRC_DEPTH = 16,
   parameter int SNK_DEPTH = 16,
   localparam int SRC_AW = $clog2(SRC_DEPTH),
   localparam int SNK_AW = $clog2(SNK_DEPTH),
   localparam int LD_AW  = $clog2((SRC_DEPTH > SNK_DEPTH) ? SRC_DEPTH : SNK_DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ld_src_val,
   input  logic                 ld_snk_val,
   input  logic [LD_AW-1:0]     ld_addr,
   input  logic [31:0]          ld_data,
   input  logic [SRC_AW:0]      src_num,
   input  logic [SNK_AW:0]      snk_num,
   input  logic                 start,
   mngr_test_agent_if.master    mngr,
   output logic                 done,
   output logic                 pass,
   output logic [SNK_AW-1:0]    err_idx,
   output logic [31:0]          err_data
);

   typedef enum logic [1:0] {IDLE, RUN, DONE, FAIL} state_t;

   localparam logic [SRC_AW:0] SRC_MAX    = (SRC_AW+1)'(SRC_DEPTH);
   localparam logic [SNK_AW:0] SNK_MAX    = (SNK_AW+1)'(SNK_DEPTH);
   localparam logic [LD_AW:0]  SRC_LD_LIM = (LD_AW+1)'(SRC_DEPTH);
   localparam logic [LD_AW:0]  SNK_LD_LIM = (LD_AW+1)'(SNK_DEPTH);

   state_t            state, state_nxt;
   logic [31:0]       src_tbl [SRC_DEPTH];
   logic [31:0]       snk_tbl [SNK_DEPTH];
   logic [SRC_AW:0]   src_ptr, src_ptr_nxt, src_cnt;
   logic [SNK_AW:0]   snk_ptr, snk_ptr_nxt, snk_cnt;
   logic              src_avail, snk_avail;
   logic              src_val, snk_rdy;
   logic              src_fire, snk_fire, mismatch;
   logic              launch;

   assign launch    = start && (state != RUN);
   assign src_avail = (state == RUN) && (src_ptr < src_cnt);
   assign snk_avail = (state == RUN) && (snk_ptr < snk_cnt);

`ifdef MNGR_AGENT_RAND_DELAY_EN
   logic [15:0] lfsr;
   logic        src_stall, snk_stall;

   assign src_val = src_avail && !src_stall;
   assign snk_rdy = snk_avail && !snk_stall;

   // The source stall bit is only resampled while val is low or just handshook, so a pending message never drops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr      <= 16'hACE1;
         src_stall <= 1'b0;
         snk_stall <= 1'b0;
      end else if (launch) begin
         lfsr      <= 16'hACE1;
         src_stall <= 1'b0;
         snk_stall <= 1'b0;
      end else begin
         lfsr      <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         if (!src_val || src_fire)
            src_stall <= lfsr[0];
         snk_stall <= lfsr[7];
      end
   end
`else
   assign src_val = src_avail;
   assign snk_rdy = snk_avail;
`endif

   assign mngr.mngr2proc_val = src_val;
   assign mngr.mngr2proc_msg = src_val ? src_tbl[src_ptr[SRC_AW-1:0]] : 32'h0;
   assign mngr.proc2mngr_rdy = snk_rdy;

   assign src_fire = src_val && mngr.mngr2proc_rdy;
   assign snk_fire = snk_rdy && mngr.proc2mngr_val;
   assign mismatch = snk_fire && (mngr.proc2mngr_msg != snk_tbl[snk_ptr[SNK_AW-1:0]]);

   assign src_ptr_nxt = src_ptr + {{SRC_AW{1'b0}}, src_fire};
   assign snk_ptr_nxt = snk_ptr + {{SNK_AW{1'b0}}, snk_fire && !mismatch};

   assign done = (state == DONE) || (state == FAIL);
   assign pass = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Completion looks at the post-transfer pointers so done rises the cycle after the last handshake
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:       if (start) state_nxt = RUN;
         RUN: begin
            if (mismatch)
               state_nxt = FAIL;
            else if ((src_ptr_nxt == src_cnt) && (snk_ptr_nxt == snk_cnt))
               state_nxt = DONE;
         end
         DONE, FAIL: if (start) state_nxt = RUN;
         default:    state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src_ptr  <= '0;
         snk_ptr  <= '0;
         src_cnt  <= '0;
         snk_cnt  <= '0;
         err_idx  <= '0;
         err_data <= '0;
      end else if (launch) begin
         src_ptr  <= '0;
         snk_ptr  <= '0;
         src_cnt  <= (src_num > SRC_MAX) ? SRC_MAX : src_num;
         snk_cnt  <= (snk_num > SNK_MAX) ? SNK_MAX : snk_num;
         err_idx  <= '0;
         err_data <= '0;
      end else if (state == RUN) begin
         src_ptr <= src_ptr_nxt;
         snk_ptr <= snk_ptr_nxt;
         if (mismatch) begin
            err_idx  <= snk_ptr[SNK_AW-1:0];
            err_data <= mngr.proc2mngr_msg;
         end
      end
   end

   // Tables have no reset so their contents survive a mid-run reset
   always_ff @(posedge clk) begin
      if (ld_src_val && (state != RUN) && ({1'b0, ld_addr} < SRC_LD_LIM))
         src_tbl[ld_addr[SRC_AW-1:0]] <= ld_data;
      if (ld_snk_val && (state != RUN) && ({1'b0, ld_addr} < SNK_LD_LIM))
         snk_tbl[ld_addr[SNK_AW-1:0]] <= ld_data;
   end

endmodule

// File: tb/tb_mngr_test_agent.sv
// Scoreboard bench for mngr_test_agent: a random core model drives the ports, expected
// source messages and run outcomes are queued at issue time and checked by a monitor.
module tb_mngr_test_agent;

   localparam int SRC_DEPTH = 16;
   localparam int SNK_DEPTH = 16;

   typedef struct {
      bit          pass_e;
      int          idx;
      logic [31:0] data;
      int          accepted;
   } result_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        ld_src_val, ld_snk_val;
   logic [3:0]  ld_addr;
   logic [31:0] ld_data;
   logic [4:0]  src_num, snk_num;
   logic        start;
   logic        done, pass;
   logic [3:0]  err_idx;
   logic [31:0] err_data;

   mngr_test_agent_if mif();

   mngr_test_agent #(.SRC_DEPTH(SRC_DEPTH), .SNK_DEPTH(SNK_DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ld_src_val (ld_src_val),
      .ld_snk_val (ld_snk_val),
      .ld_addr    (ld_addr),
      .ld_data    (ld_data),
      .src_num    (src_num),
      .snk_num    (snk_num),
      .start      (start),
      .mngr       (mif),
      .done       (done),
      .pass       (pass),
      .err_idx    (err_idx),
      .err_data   (err_data)
   );

   always #5 clk = ~clk;

   logic [31:0] src_tbl_m [SRC_DEPTH];
   logic [31:0] snk_tbl_m [SNK_DEPTH];
   logic [31:0] src_exp_q [$];
   logic [31:0] core_q [$];
   result_t     res_q [$];

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int start_cyc = 0;
   int last_fire_cyc = 0;
   int done_cyc_last = 0;
   int snk_seen = 0;
   int runs_done = 0;
   bit core_en = 1'b0;
   int rdy_hold = 0;
   int rdy_pct = 100;
   int val_pct = 100;
   bit done_q = 1'b0;
   bit p2m_fire;
   result_t mon_r;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Core model: random ready on mngr2proc, random valid on proc2mngr from core_q
   always begin
      @(negedge clk);
      p2m_fire = mif.proc2mngr_val && mif.proc2mngr_rdy;
      @(posedge clk);
      #1;
      if (!core_en) begin
         mif.mngr2proc_rdy = 1'b0;
         mif.proc2mngr_val = 1'b0;
         mif.proc2mngr_msg = 32'h0;
      end else begin
         if (p2m_fire && core_q.size() > 0)
            void'(core_q.pop_front());
         if (rdy_hold > 0) begin
            mif.mngr2proc_rdy = 1'b0;
            rdy_hold--;
         end else begin
            mif.mngr2proc_rdy = ($urandom_range(99, 0) < rdy_pct);
         end
         mif.proc2mngr_val = (core_q.size() > 0) && ($urandom_range(99, 0) < val_pct);
         mif.proc2mngr_msg = (core_q.size() > 0) ? core_q[0] : $urandom;
      end
   end

   // Monitor: samples on the falling edge, checks source stream and run outcomes
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         done_q = 1'b0;
      end else begin
         if (start) begin
            start_cyc     = cyc;
            last_fire_cyc = 0;
            snk_seen      = 0;
         end
         if (mif.mngr2proc_val) begin
            if (src_exp_q.size() == 0) begin
               checkOutput("src_unexpected_val", {31'b0, mif.mngr2proc_val}, 32'd0);
            end else begin
               checkOutput("src_msg", mif.mngr2proc_msg, src_exp_q[0]);
               if (mif.mngr2proc_rdy) begin
                  void'(src_exp_q.pop_front());
                  last_fire_cyc = cyc;
               end
            end
         end else begin
            checkOutput("src_msg_idle", mif.mngr2proc_msg, 32'd0);
         end
         if (mif.proc2mngr_val && mif.proc2mngr_rdy) begin
            if (res_q.size() > 0 && snk_seen >= res_q[0].accepted)
               checkOutput("snk_extra_accept", {31'b0, mif.proc2mngr_rdy}, 32'd0);
            snk_seen++;
            last_fire_cyc = cyc;
         end
         if (done && !done_q) begin
            done_cyc_last = cyc;
            if (res_q.size() == 0) begin
               checkOutput("done_unexpected", {31'b0, done}, 32'd0);
            end else begin
               mon_r = res_q.pop_front();
               checkOutput("pass", {31'b0, pass}, {31'b0, mon_r.pass_e});
               checkOutput("accepted", snk_seen, mon_r.accepted);
               checkOutput("done_cycle", cyc,
                           (start_cyc + 1 > last_fire_cyc) ? start_cyc + 2 : last_fire_cyc + 1);
               checkOutput("rdy_after_done", {31'b0, mif.proc2mngr_rdy}, 32'd0);
               if (!mon_r.pass_e) begin
                  checkOutput("err_idx", {28'b0, err_idx}, mon_r.idx);
                  checkOutput("err_data", err_data, mon_r.data);
               end else begin
                  checkOutput("src_leftover", src_exp_q.size(), 32'd0);
               end
            end
            src_exp_q.delete();
            runs_done++;
         end
         done_q = done;
      end
   end

   task automatic loadEntry(input bit is_src, input int addr, input logic [31:0] d);
      @(posedge clk);
      #1;
      ld_src_val = is_src;
      ld_snk_val = !is_src;
      ld_addr    = addr[3:0];
      ld_data    = d;
      if (is_src) src_tbl_m[addr] = d;
      else        snk_tbl_m[addr] = d;
   endtask

   task automatic ldOff();
      @(posedge clk);
      #1;
      ld_src_val = 1'b0;
      ld_snk_val = 1'b0;
   endtask

   // Queue the model's expectations for a run, then pulse start with garbage loads behind it
   task automatic applyStimulus(input int ns_raw, input int nk_raw);
      int ns, nk;
      result_t r;
      ns = (ns_raw > SRC_DEPTH) ? SRC_DEPTH : ns_raw;
      nk = (nk_raw > SNK_DEPTH) ? SNK_DEPTH : nk_raw;
      for (int i = 0; i < ns; i++) src_exp_q.push_back(src_tbl_m[i]);
      r.pass_e = 1'b1;
      r.idx = 0;
      r.data = 32'h0;
      r.accepted = nk;
      for (int i = 0; i < nk; i++) begin
         if (i >= core_q.size() || core_q[i] !== snk_tbl_m[i]) begin
            r.pass_e = 1'b0;
            r.idx = i;
            r.data = (i < core_q.size()) ? core_q[i] : 32'h0;
            r.accepted = i + 1;
            break;
         end
      end
      res_q.push_back(r);
      @(posedge clk);
      #1;
      src_num = ns_raw[4:0];
      snk_num = nk_raw[4:0];
      start   = 1'b1;
      @(posedge clk);
      #1;
      start      = 1'b0;
      src_num    = 5'($urandom);
      snk_num    = 5'($urandom);
      ld_src_val = 1'b1;
      ld_snk_val = 1'b1;
      ld_addr    = 4'($urandom);
      ld_data    = $urandom;
      @(posedge clk);
      #1;
      ld_src_val = 1'b0;
      ld_snk_val = 1'b0;
   endtask

   task automatic waitRun(input int target);
      int n;
      n = 0;
      while (runs_done < target && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (runs_done < target) begin
         checkOutput("run_timeout", {31'b0, done}, 32'd1);
         res_q.delete();
         src_exp_q.delete();
      end
      core_q.delete();
   endtask

   int target, ns_raw, nk_raw, nk, extra, j, n;

   initial begin
      ld_src_val = 1'b0;
      ld_snk_val = 1'b0;
      ld_addr    = '0;
      ld_data    = '0;
      src_num    = '0;
      snk_num    = '0;
      start      = 1'b0;
      mif.mngr2proc_rdy = 1'b0;
      mif.proc2mngr_val = 1'b0;
      mif.proc2mngr_msg = 32'h0;

      #2 rst_n = 1'b0;
      #1;
      checkOutput("rst_val", {31'b0, mif.mngr2proc_val}, 32'd0);
      checkOutput("rst_msg", mif.mngr2proc_msg, 32'd0);
      checkOutput("rst_rdy", {31'b0, mif.proc2mngr_rdy}, 32'd0);
      checkOutput("rst_done", {31'b0, done}, 32'd0);
      checkOutput("rst_pass", {31'b0, pass}, 32'd0);
      checkOutput("rst_err_idx", {28'b0, err_idx}, 32'd0);
      checkOutput("rst_err_data", err_data, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      core_en = 1'b1;

      $display("[TB] loopback 1,2,3 at full throughput");
      for (int i = 0; i < 3; i++) loadEntry(1'b1, i, 32'(i + 1));
      for (int i = 0; i < 3; i++) loadEntry(1'b0, i, 32'(i + 1));
      ldOff();
      core_q = '{32'd1, 32'd2, 32'd3};
      rdy_pct = 100;
      val_pct = 100;
      target = runs_done + 1;
      applyStimulus(3, 3);
      waitRun(target);
      checkOutput("t1_latency", done_cyc_last - start_cyc, 32'd4);

      $display("[TB] mismatch on second sink message");
      for (int i = 0; i < 3; i++) loadEntry(1'b0, i, 32'(i + 5));
      ldOff();
      core_q = '{32'd5, 32'd9, 32'd7};
      target = runs_done + 1;
      applyStimulus(3, 3);
      waitRun(target);
      checkOutput("t2_err_idx", {28'b0, err_idx}, 32'd1);
      checkOutput("t2_err_data", err_data, 32'd9);
      checkOutput("t2_pass", {31'b0, pass}, 32'd0);

      $display("[TB] source held while core not ready");
      rdy_hold = 6;
      target = runs_done + 1;
      applyStimulus(2, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("hold_val", {31'b0, mif.mngr2proc_val}, 32'd1);
         checkOutput("hold_msg", mif.mngr2proc_msg, src_tbl_m[0]);
      end
      waitRun(target);

      $display("[TB] extra core output beyond snk_num");
      core_q = '{32'd5, 32'd6, 32'd123};
      target = runs_done + 1;
      applyStimulus(1, 2);
      waitRun(target);

      $display("[TB] reset mid-run, then rerun from index 0");
      core_q = '{32'd5, 32'd6, 32'd7};
      target = runs_done + 1;
      applyStimulus(3, 3);
      n = 0;
      while (snk_seen < 1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checkOutput("t5_first_transfer", snk_seen, 32'd1);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      checkOutput("t5_rst_val", {31'b0, mif.mngr2proc_val}, 32'd0);
      checkOutput("t5_rst_rdy", {31'b0, mif.proc2mngr_rdy}, 32'd0);
      checkOutput("t5_rst_done", {31'b0, done}, 32'd0);
      core_en = 1'b0;
      core_q.delete();
      src_exp_q.delete();
      res_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      core_q = '{32'd5, 32'd6, 32'd7};
      core_en = 1'b1;
      target = runs_done + 1;
      applyStimulus(3, 3);
      waitRun(target);
      checkOutput("t5_rerun_pass", {31'b0, pass}, 32'd1);

      $display("[TB] zero-length run");
      target = runs_done + 1;
      applyStimulus(0, 0);
      waitRun(target);
      checkOutput("t6_latency", done_cyc_last - start_cyc, 32'd2);

      $display("[TB] randomized runs");
      for (int t = 0; t < 30; t++) begin
         n = $urandom_range(6, 0);
         for (int k = 0; k < n; k++)
            loadEntry(1'($urandom_range(1, 0)), $urandom_range(15, 0), $urandom);
         ldOff();
         ns_raw = $urandom_range(31, 0);
         nk_raw = $urandom_range(31, 0);
         nk = (nk_raw > SNK_DEPTH) ? SNK_DEPTH : nk_raw;
         for (int i = 0; i < nk; i++) core_q.push_back(snk_tbl_m[i]);
         if (nk > 0 && $urandom_range(2, 0) == 0) begin
            j = $urandom_range(nk - 1, 0);
            core_q[j] = core_q[j] ^ (32'd1 << $urandom_range(31, 0));
         end
         extra = $urandom_range(3, 0);
         for (int i = 0; i < extra; i++) core_q.push_back($urandom);
         rdy_pct = $urandom_range(100, 30);
         val_pct = $urandom_range(100, 30);
         target = runs_done + 1;
         applyStimulus(ns_raw, nk_raw);
         waitRun(target);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
